// File: rtl/fp_pkg.sv
// fp_pkg: shared types and helpers for the floating-point datapath blocks.
//   fp_state_e     - control states of the streaming dot-product engine
//   fp_width()     - total word width from exponent and fraction widths
//   fp_is_special()- true when an exponent field is all ones (Inf or NaN)
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DRAIN,
        DONE
    } fp_state_e;

    function automatic int fp_width(input int exp_w, input int frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    // exp_f carries the exponent field zero-extended to 32 bits.
    function automatic logic fp_is_special(input logic [31:0] exp_f, input int exp_w);
        logic [31:0] mask;
        mask = (32'd1 << exp_w) - 32'd1;
        return (exp_f & mask) == mask;
    endfunction

endpackage

// File: rtl/fp_add.sv
// fp_add: combinational floating-point adder, round-to-nearest-even.
// Subnormal inputs are treated as zero and subnormal results flush to zero.
//   a_i, b_i : operands (sign | exponent | fraction)
//   y_o      : sum
module fp_add #(
    parameter int EXP_W = 8,
    parameter int FRAC_W = 23,
    localparam int W = 1 + EXP_W + FRAC_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);
    // Working mantissa: hidden bit, fraction, guard/round/sticky.
    localparam int M    = FRAC_W + 4;
    localparam int EMAX = (1 << EXP_W) - 1;

    logic              sa, sb, sx, sy, swap, found, up;
    logic [EXP_W-1:0]  ea, eb, ex, ey;
    logic [FRAC_W-1:0] fa, fb, fx, fy;
    logic              a_z, b_z, a_inf, b_inf, a_nan, b_nan;
    logic [M-1:0]      mx, my, al;
    logic [2*M-1:0]    sh;
    logic [M:0]        sum;
    logic [M-2:0]      n;
    logic [FRAC_W:0]   frac_r;
    int                d, lz, e;

    assign {sa, ea, fa} = a_i;
    assign {sb, eb, fb} = b_i;
    assign a_z   = (ea == '0);
    assign b_z   = (eb == '0);
    assign a_inf = (ea == '1) && (fa == '0);
    assign b_inf = (eb == '1) && (fb == '0);
    assign a_nan = (ea == '1) && (fa != '0);
    assign b_nan = (eb == '1) && (fb != '0);

    always_comb begin
        swap         = {eb, fb} > {ea, fa};
        {sx, ex, fx} = swap ? b_i : a_i;
        {sy, ey, fy} = swap ? a_i : b_i;
        mx = {1'b1, fx, 3'b000};
        my = {1'b1, fy, 3'b000};
        d  = int'(ex) - int'(ey);
        if (d > M + 1) d = M + 1;
        // Bits shifted out of the smaller operand collapse into a sticky LSB.
        sh  = {my, {M{1'b0}}} >> d;
        al  = sh[2*M-1:M] | {{(M-1){1'b0}}, |sh[M-1:0]};
        sum = (sx == sy) ? {1'b0, mx} + {1'b0, al} : {1'b0, mx} - {1'b0, al};
        lz    = 0;
        found = 1'b0;
        for (int i = M - 1; i >= 0; i--) begin
            if (!found) begin
                if (sum[i]) found = 1'b1;
                else        lz = lz + 1;
            end
        end
        e = int'(ex);
        if (sum[M]) begin
            n = {sum[M-1:2], sum[1] | sum[0]};
            e = e + 1;
        end else begin
            n = (M-1)'(sum[M-2:0] << lz);
            e = e - lz;
        end
        up     = n[2] & (n[1] | n[0] | n[3]);
        frac_r = {1'b0, n[M-2:3]} + (FRAC_W+1)'(up);
        e      = e + int'(frac_r[FRAC_W]);
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            y_o = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
        end else if (a_inf) begin
            y_o = a_i;
        end else if (b_inf) begin
            y_o = b_i;
        end else if (a_z && b_z) begin
            y_o = {sa & sb, {(W-1){1'b0}}};
        end else if (a_z) begin
            y_o = b_i;
        end else if (b_z) begin
            y_o = a_i;
        end else if (sum == '0 || e <= 0) begin
            y_o = '0;
        end else if (e >= EMAX) begin
            y_o = {sx, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            y_o = {sx, EXP_W'(e), frac_r[FRAC_W-1:0]};
        end
    end

endmodule

// File: rtl/fp_mul.sv
// fp_mul: combinational floating-point multiplier, round-to-nearest-even.
// Subnormal inputs and results are flushed to signed zero.
//   a_i, b_i : operands (sign | exponent | fraction)
//   y_o      : product
module fp_mul #(
    parameter int EXP_W = 8,
    parameter int FRAC_W = 23,
    localparam int W = 1 + EXP_W + FRAC_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);
    localparam int M    = FRAC_W + 1;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 1;

    logic              sa, sb, sy;
    logic [EXP_W-1:0]  ea, eb;
    logic [FRAC_W-1:0] fa, fb;
    logic              a_z, b_z, a_inf, b_inf, a_nan, b_nan;
    logic [2*M-1:0]    prod;
    logic [2*M-2:0]    norm;
    logic [FRAC_W:0]   frac_r;
    logic              up;
    int                e;

    assign {sa, ea, fa} = a_i;
    assign {sb, eb, fb} = b_i;
    assign sy    = sa ^ sb;
    assign a_z   = (ea == '0);
    assign b_z   = (eb == '0);
    assign a_inf = (ea == '1) && (fa == '0);
    assign b_inf = (eb == '1) && (fb == '0);
    assign a_nan = (ea == '1) && (fa != '0);
    assign b_nan = (eb == '1) && (fb != '0);

    always_comb begin
        prod = (2*M)'({1'b1, fa}) * (2*M)'({1'b1, fb});
        // Drop the hidden bit after normalising; norm holds fraction, guard, sticky bits.
        norm   = prod[2*M-1] ? prod[2*M-2:0] : {prod[2*M-3:0], 1'b0};
        up     = norm[M-1] & ((|norm[M-2:0]) | norm[M]);
        frac_r = {1'b0, norm[2*M-2:M]} + (FRAC_W+1)'(up);
        e      = int'(ea) + int'(eb) - BIAS + int'(prod[2*M-1]) + int'(frac_r[FRAC_W]);
        if (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z)) begin
            y_o = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
        end else if (a_inf || b_inf || e >= EMAX) begin
            y_o = {sy, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (a_z || b_z || e <= 0) begin
            y_o = {sy, {(W-1){1'b0}}};
        end else begin
            y_o = {sy, EXP_W'(e), frac_r[FRAC_W-1:0]};
        end
    end

endmodule

// File: rtl/fp_dot_acc.sv
// fp_dot_acc: streaming floating-point dot product with bias.
// Each accepted (a, b) pair is multiplied into a product register (stage 1);
// the following edge adds it onto the running sum, seeded with the bias for
// the first pair of a vector (stage 2). One result per vector is offered on
// the out_* handshake.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake; in_a, in_b operands, in_bias start
//                       value (first pair only), in_last marks final pair
//   out_valid/out_ready: result handshake; out_result accumulated sum
//   out_count, out_special: element count and sticky Inf/NaN flag, built only
//                       when FP_DOT_STATUS_EN is defined, otherwise tied to 0
module fp_dot_acc
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int FRAC_W = 23,
    parameter int CNT_W = 16,
    localparam int WIDTH = fp_width(EXP_W, FRAC_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_bias,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [CNT_W-1:0] out_count,
    output logic             out_special
);
    fp_state_e        st_q, st_d;
    logic [WIDTH-1:0] prod, sum, add_lhs;
    logic [WIDTH-1:0] p_q, bias_q, acc_q;
    logic             p_valid_q, p_first_q, p_last_q;
    logic             accept, first_acc;

    assign accept    = in_valid & in_ready;
    assign first_acc = accept & (st_q == IDLE);

    fp_mul #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_mul (
        .a_i(in_a),
        .b_i(in_b),
        .y_o(prod)
    );

    assign add_lhs = p_first_q ? bias_q : acc_q;

    fp_add #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_add (
        .a_i(add_lhs),
        .b_i(p_q),
        .y_o(sum)
    );

    always_comb begin
        st_d      = st_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (st_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) st_d = in_last ? DRAIN : ACC;
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) st_d = DRAIN;
            end
            // Leave only once the last product has been folded into acc_q.
            DRAIN: begin
                if (!(p_valid_q && p_last_q)) st_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= IDLE;
            p_valid_q <= 1'b0;
            p_first_q <= 1'b0;
            p_last_q  <= 1'b0;
            acc_q     <= '0;
        end else begin
            st_q      <= st_d;
            p_valid_q <= accept;
            p_first_q <= first_acc;
            p_last_q  <= in_last;
            if (p_valid_q) acc_q <= sum;
        end
    end

    // Operand-side data registers carry no reset; p_valid_q qualifies them.
    always_ff @(posedge clk) begin
        if (accept)    p_q    <= prod;
        if (first_acc) bias_q <= in_bias;
    end

    assign out_result = acc_q;

`ifdef FP_DOT_STATUS_EN
    logic [CNT_W-1:0] cnt_q;
    logic             spec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            spec_q <= 1'b0;
        end else begin
            if (first_acc)                  cnt_q <= CNT_W'(1);
            else if (accept && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (first_acc) begin
                spec_q <= 1'b0;
            end else if (p_valid_q &&
                         (fp_is_special(32'(p_q[WIDTH-2 -: EXP_W]), EXP_W) ||
                          fp_is_special(32'(sum[WIDTH-2 -: EXP_W]), EXP_W))) begin
                spec_q <= 1'b1;
            end
        end
    end

    assign out_count   = cnt_q;
    assign out_special = spec_q;
`else
    assign out_count   = '0;
    assign out_special = 1'b0;
`endif

endmodule

// File: tb/tb_fp_dot_acc.sv
module tb_fp_dot_acc;
    localparam int EXP_W = 8;
    localparam int FRAC_W = 23;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [31:0] in_a, in_b, in_bias;
    logic        out_valid, out_ready, out_special;
    logic [31:0] out_result;
    logic [CNT_W-1:0] out_count;

    int tests = 0;
    int fails = 0;

    fp_dot_acc #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_bias(in_bias), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_count(out_count), .out_special(out_special)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] bias;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [31:0] res;
        logic [1:0]  n;
        logic        spec;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mk(input logic [31:0] bias, input logic [1:0] n,
                                input logic [31:0] a0, input logic [31:0] b0,
                                input logic [31:0] a1, input logic [31:0] b1,
                                input logic [31:0] res, input logic spec);
        vec_t v;
        v.bias = bias; v.n = n; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
        v.res = res; v.spec = spec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pair(input string nm, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] bias, input logic last);
        in_valid = 1'b1; in_a = a; in_b = b; in_bias = bias; in_last = last;
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; in_last = 1'b0; in_bias = 32'h44444444;
    endtask

    task automatic check_status(input string nm, input int cnt, input logic spec);
`ifdef FP_DOT_STATUS_EN
        chk({nm, "_count"}, 32'(out_count), 32'(cnt));
        chk({nm, "_special"}, 32'(out_special), 32'(spec));
`else
        chk({nm, "_count"}, 32'(out_count), 32'(0 * cnt));
        chk({nm, "_special"}, 32'(out_special), 32'(1'b0 & spec));
`endif
    endtask

    // Called #1 after the edge that accepted the last pair.
    task automatic finish_vec(input string nm, input logic [31:0] res, input int cnt,
                              input logic spec);
        int cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 8) begin
            tick();
            cyc++;
        end
        chk({nm, "_latency"}, 32'(cyc), 32'd2);
        chk({nm, "_result"}, out_result, res);
        chk({nm, "_ready_in_done"}, 32'(in_ready), 32'd0);
        check_status(nm, cnt, spec);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({nm, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        tbl[0] = mk(32'h3F800000, 2'd2, 32'h40000000, 32'h40400000, 32'h40800000, 32'h3F000000, 32'h41100000, 1'b0);
        tbl[1] = mk(32'h00000000, 2'd1, 32'h40000000, 32'h40000000, 32'h0, 32'h0, 32'h40800000, 1'b0);
        tbl[2] = mk(32'h40A00000, 2'd1, 32'h3F800000, 32'hBF800000, 32'h0, 32'h0, 32'h40800000, 1'b0);
        tbl[3] = mk(32'h00000000, 2'd2, 32'h40400000, 32'h40400000, 32'hC0000000, 32'h40800000, 32'h3F800000, 1'b0);
        tbl[4] = mk(32'h3F800000, 2'd1, 32'h00000000, 32'h42000000, 32'h0, 32'h0, 32'h3F800000, 1'b0);
        tbl[5] = mk(32'hC1200000, 2'd1, 32'h40A00000, 32'h40000000, 32'h0, 32'h0, 32'h00000000, 1'b0);
        tbl[6] = mk(32'h00000000, 2'd1, 32'h3FC00000, 32'h3FC00000, 32'h0, 32'h0, 32'h40100000, 1'b0);
        tbl[7] = mk(32'h00000000, 2'd1, 32'h7F800000, 32'h3F800000, 32'h0, 32'h0, 32'h7F800000, 1'b1);
        tbl[8] = mk(32'h00000000, 2'd2, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0);

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_bias = '0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_result", out_result, 32'h0);
        check_status("reset", 0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // out_ready with nothing pending must not disturb anything
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_out_ready_valid", 32'(out_valid), 32'd0);
        chk("idle_out_ready_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive_pair(nm, tbl[i].a0, tbl[i].b0, tbl[i].bias, tbl[i].n == 2'd1);
            if (tbl[i].n == 2'd2) drive_pair(nm, tbl[i].a1, tbl[i].b1, 32'h44444444, 1'b1);
            finish_vec(nm, tbl[i].res, int'(tbl[i].n), tbl[i].spec);
        end

        // Held output: result stays put and input side stays closed
        drive_pair("hold", 32'h40000000, 32'h40000000, 32'h00000000, 1'b1);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 8) begin
            chk("hold_ready_drain", 32'(in_ready), 32'd0);
            tick();
            cyc++;
        end
        chk("hold_latency", 32'(cyc), 32'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", out_result, 32'h40800000);
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_release_valid", 32'(out_valid), 32'd0);
        chk("hold_release_ready", 32'(in_ready), 32'd1);

        // Gaps between pairs within one vector
        drive_pair("gap", 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0);
        tick(); chk("gap_ready1", 32'(in_ready), 32'd1);
        tick(); chk("gap_ready2", 32'(in_ready), 32'd1);
        drive_pair("gap", 32'h3F800000, 32'h3F800000, 32'h44444444, 1'b0);
        tick(); tick();
        chk("gap_valid_mid", 32'(out_valid), 32'd0);
        drive_pair("gap", 32'h3F800000, 32'h3F800000, 32'h44444444, 1'b1);
        finish_vec("gap", 32'h40400000, 3, 1'b0);

        // Asynchronous reset in the middle of a vector
        drive_pair("rstmid", 32'h40000000, 32'h40000000, 32'h3F800000, 1'b0);
        drive_pair("rstmid", 32'h40000000, 32'h40000000, 32'h44444444, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_out_valid", 32'(out_valid), 32'd0);
        chk("rstmid_in_ready", 32'(in_ready), 32'd1);
        chk("rstmid_result", out_result, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        drive_pair("after_rst", 32'h3F800000, 32'h40000000, 32'h00000000, 1'b1);
        finish_vec("after_rst", 32'h40000000, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_dot_acc.md
Name: fp_dot_acc

Overview:
Sequential floating-point dot-product engine, parametrised in exponent and fraction width. Accepts a stream of (a, b) operand pairs under valid/ready handshake and multiplies each pair. Accumulates the products onto a bias value and presents one result per vector under a second handshake. Instantiates the team's existing combinational fp_mul and fp_add, with a register stage between them; it is the streaming successor to the single-shot multiply-add.

Parameters:
EXP_W, 8, exponent field width
FRAC_W, 23, fraction field width (WIDTH = 1+EXP_W+FRAC_W)
CNT_W, 16, element-counter width (used only with the optional feature)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept a pair
in_a  in  WIDTH  multiplicand
in_b  in  WIDTH  multiplier
in_bias  in  WIDTH  accumulator start value, sampled only with the first pair of a vector
in_last  in  1  pair is final element of the vector
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  accumulated sum
out_count  out  CNT_W  elements in vector (optional feature only)
out_special  out  1  sticky NaN/Inf seen (optional feature only)

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_result=0, stage-1 valid=0, optional count/flag=0. Reset mid-vector discards all partial data.
- Accept = in_valid & in_ready at a rising edge.
- FSM states are IDLE, ACC, DRAIN and DONE.
- IDLE: in_ready=1. On accept, go to ACC, or to DRAIN if in_last; the pair is tagged first and in_bias is captured.
- ACC: in_ready=1. Accept with in_last goes to DRAIN. Gaps in in_valid are allowed and do not disturb the accumulator.
- DRAIN: in_ready=0. After the stage-2 update of the last product, go to DONE.
- DONE: in_ready=0, out_valid=1, out_result stable. On out_ready, go to IDLE and drop out_valid on the same edge.
- Stage 1, on the accept edge: p_q <= fp_mul(in_a, in_b); p_valid, p_first and p_last are registered alongside.
- Stage 2, edge after stage 1: if p_valid, acc <= fp_add(p_first ? bias_q : acc, p_q).
- Latency: last pair accepted at edge k; out_valid is high after edge k+2. A single-element vector has the same latency.
- Throughput: one pair per cycle within a vector. The next vector's first pair can be accepted on the cycle after the output handshake.
- in_last on the first pair is legal and yields bias + a*b.
- in_valid while in DRAIN or DONE is ignored because in_ready=0; the operands must be held by the source.
- out_ready while out_valid=0 has no effect.
- Rounding and special values are exactly those of fp_mul/fp_add; no extra normalisation.

Optional Feature:
Macro FP_DOT_STATUS_EN.
- Defined: out_count holds the number of pairs accepted in the current vector, saturating at 2^CNT_W-1 and cleared on the first accept. out_special goes high if any product or the accumulator has an all-ones exponent, and is cleared on the first accept. Both are valid with out_valid.
- Undefined: out_count and out_special are tied to 0 and no counter or flag logic is built.

Decomposition:
- Package fp_pkg holds: the state enum typedef (IDLE, ACC, DRAIN, DONE); the function fp_is_special(exp field) used by the optional feature; and the WIDTH-computing localparam convention.
- fp_mul and fp_add are reused unmodified.
- No new sub-module is needed; the FSM and both pipeline registers live in fp_dot_acc.

Test Plan:
- EXP_W=8/FRAC_W=23, bias 3F800000 (1.0); pairs (40000000,40400000), then (40800000,3F000000) with last -> out_result 41100000 (9.0), out_valid 2 edges after last accept; with the feature, out_count=2.
- Single pair with last: bias 00000000, (40000000,40000000) -> out_result 40800000 (4.0); in_ready=0 from the accept edge until the output handshake.
- Hold out_ready=0 for 5 cycles after out_valid -> out_result and out_valid stable and in_ready=0 throughout; out_ready=1 -> IDLE next edge and in_ready=1.
- in_valid gaps: pairs (3F800000,3F800000) x3 with 2 idle cycles between them, bias 0 -> 40400000 (3.0).
- Assert rst for 1 cycle mid-vector after 2 accepts -> immediately out_valid=0 and in_ready=1; a new vector with bias 0 and (3F800000,40000000, last) yields 40000000 (2.0), with no residue.
- With the feature: pair (7F800000,3F800000) -> out_special=1; a following clean vector -> out_special=0.
